pkt_checker: RTL

- Downstream consumer of the UART receiver's 208-bit packet bus. It validates each received packet, then extracts the board and move fields for game_fsm.
- Checks: sync byte, reserved bits, serial CRC-16 and sequence-number duplicate filtering.
- Good packets update registered board/move outputs with a one-cycle valid pulse. Bad packets raise an error pulse with a cause code.

---
 rtl/comm_pkg.sv | 42 ++++
 rtl/crc16_serial.sv | 24 ++
 rtl/pkt_checker.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// Shared packet-format definitions for the board/move link (RX checker and TX framer).
package comm_pkg;

  localparam int PKT_LEN    = 208;
  localparam int BOARD_BITS = 162;
  localparam int CRC_W      = 16;
  localparam int CRC_SPAN   = PKT_LEN - CRC_W;  // bits covered by the CRC

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [7:0]  MOVE_NONE = 8'hFF;

  // Field positions, MSB first on the wire
  localparam int SYNC_MSB  = 207;
  localparam int SYNC_LSB  = 200;
  localparam int SEQ_MSB   = 199;
  localparam int SEQ_LSB   = 192;
  localparam int BOARD_MSB = 191;
  localparam int BOARD_LSB = 30;
  localparam int MOVE_MSB  = 29;
  localparam int MOVE_LSB  = 22;
  localparam int RSVD_MSB  = 21;
  localparam int RSVD_LSB  = 16;
  localparam int CRC_MSB   = 15;
  localparam int CRC_LSB   = 0;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SYNC = 2'd1,
    ERR_RSVD = 2'd2,
    ERR_CRC  = 2'd3
  } err_code_e;

  // One serial CRC-16 step, MSB-first data
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 register; init reloads the seed, en folds in one bit.
module crc16_serial
  import comm_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q;

  // Seed on init, otherwise shift one data bit per enabled cycle
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)    crc_q <= CRC_INIT;
    else if (init) crc_q <= CRC_INIT;
    else if (en)   crc_q <= crc16_step(crc_q, bit_in);
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/pkt_checker.sv
// Validates 208-bit packets from the UART receiver and publishes board/move.
// Flow: IDLE latches the packet, CRC rotates it through the serial CRC for
// 192 cycles, EVAL classifies it, and the following cycle applies the result.
module pkt_checker
  import comm_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_ready,
  input  logic [PKT_LEN-1:0]    rx_data,
  output logic                  busy,
  output logic                  pkt_valid,
  output logic                  pkt_dup,
  output logic                  pkt_error,
  output logic [1:0]            err_code,
  output logic                  overrun,
  output logic [BOARD_BITS-1:0] board_out,
  output logic [7:0]            move_out,
  output logic                  move_avail,
  output logic [7:0]            seq_out,
  output logic [7:0]            err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CRC  = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;

  localparam logic [7:0] LAST_BIT = 8'(CRC_SPAN - 1);

  logic [1:0]            state_q, state_d;
  logic [PKT_LEN-1:0]    sreg_q, sreg_d;
  logic [7:0]            bitcnt_q, bitcnt_d;
  logic                  busy_q;

  // Outcome of EVAL, applied to the outputs one cycle later
  logic                  res_vld_q, res_vld_d;
  logic                  res_dup_q, res_dup_d;
  err_code_e             res_code_q, res_code_d;

  logic                  pkt_valid_q, pkt_dup_q, pkt_error_q, overrun_q;
  err_code_e             err_code_q;
  logic [BOARD_BITS-1:0] board_q;
  logic [7:0]            move_q, seq_q, err_cnt_q, err_cnt_d;
  logic                  move_avail_q, seen_any_q;

  logic                  crc_init, crc_en, ovr_evt, err_evt;
  logic [15:0]           crc_val;
  logic [PKT_LEN-1:0]    pkt_orig;
  logic [8:0]            cnt_sum;

  crc16_serial u_crc (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .init    (crc_init),
    .en      (crc_en),
    .bit_in  (sreg_q[PKT_LEN-1]),
    .crc_out (crc_val)
  );

  // The shift register rotates rather than shifts, so after CRC_SPAN steps
  // the original packet is recovered by undoing the rotation.
  assign pkt_orig = {sreg_q[PKT_LEN-CRC_W-1:0], sreg_q[PKT_LEN-1:PKT_LEN-CRC_W]};

  // Next-state, datapath control and packet classification
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bitcnt_d   = bitcnt_q;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    res_vld_d  = 1'b0;
    res_dup_d  = 1'b0;
    res_code_d = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          sreg_d   = rx_data;
          bitcnt_d = 8'd0;
          crc_init = 1'b1;
          state_d  = S_CRC;
        end
      end
      S_CRC: begin
        crc_en   = 1'b1;
        sreg_d   = {sreg_q[PKT_LEN-2:0], sreg_q[PKT_LEN-1]};
        bitcnt_d = bitcnt_q + 8'd1;
        if (bitcnt_q == LAST_BIT) state_d = S_EVAL;
      end
      S_EVAL: begin
        res_vld_d = 1'b1;
        if (pkt_orig[SYNC_MSB:SYNC_LSB] != SYNC_BYTE)
          res_code_d = ERR_SYNC;
        else if (pkt_orig[RSVD_MSB:RSVD_LSB] != '0)
          res_code_d = ERR_RSVD;
        else if (crc_val != pkt_orig[CRC_MSB:CRC_LSB])
          res_code_d = ERR_CRC;
        else if (seen_any_q && (pkt_orig[SEQ_MSB:SEQ_LSB] == seq_q))
          res_dup_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any rx_ready outside IDLE (including the EVAL exit cycle) is dropped
  assign ovr_evt = rx_ready && (state_q != S_IDLE);
  assign err_evt = res_vld_q && (res_code_q != ERR_NONE);

  // Saturating error counter; error and overrun in one cycle add two
  always_comb begin
    cnt_sum   = {1'b0, err_cnt_q} + {8'd0, err_evt} + {8'd0, ovr_evt};
    err_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // FSM and packet datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      bitcnt_q   <= '0;
      busy_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_dup_q  <= 1'b0;
      res_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bitcnt_q   <= bitcnt_d;
      busy_q     <= (state_q != S_IDLE);
      res_vld_q  <= res_vld_d;
      res_dup_q  <= res_dup_d;
      res_code_q <= res_code_d;
    end
  end

  // Apply the classified result: pulses, status and accepted fields.
  // sreg_q still holds the evaluated packet here; a packet latched on this
  // same edge only lands in sreg_q afterwards.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pkt_valid_q  <= 1'b0;
      pkt_dup_q    <= 1'b0;
      pkt_error_q  <= 1'b0;
      overrun_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
      board_q      <= '0;
      move_q       <= MOVE_NONE;
      move_avail_q <= 1'b0;
      seq_q        <= '0;
      seen_any_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      pkt_valid_q <= 1'b0;
      pkt_dup_q   <= 1'b0;
      pkt_error_q <= 1'b0;
      overrun_q   <= ovr_evt;
      err_cnt_q   <= err_cnt_d;
      if (res_vld_q) begin
        if (res_code_q != ERR_NONE) begin
          pkt_error_q <= 1'b1;
          err_code_q  <= res_code_q;
        end else if (res_dup_q) begin
          pkt_dup_q <= 1'b1;
        end else begin
          pkt_valid_q  <= 1'b1;
          board_q      <= pkt_orig[BOARD_MSB:BOARD_LSB];
          move_q       <= pkt_orig[MOVE_MSB:MOVE_LSB];
          move_avail_q <= (pkt_orig[MOVE_MSB:MOVE_LSB] != MOVE_NONE);
          seq_q        <= pkt_orig[SEQ_MSB:SEQ_LSB];
          seen_any_q   <= 1'b1;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign pkt_valid  = pkt_valid_q;
  assign pkt_dup    = pkt_dup_q;
  assign pkt_error  = pkt_error_q;
  assign err_code   = err_code_q;
  assign overrun    = overrun_q;
  assign board_out  = board_q;
  assign move_out   = move_q;
  assign move_avail = move_avail_q;
  assign seq_out    = seq_q;
  assign err_count  = err_cnt_q;

endmodule
